// File: rtl/sample_fifo_pkg.sv
// Shared constants for the FM-radio pipeline stage-to-stage links.
package sample_fifo_pkg;

  // Default sample width and buffer depth on every pipeline link.
  localparam int SAMPLE_W   = 32;
  localparam int FIFO_DEPTH = 16;

endpackage : sample_fifo_pkg

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO sitting between two pipeline stages.
// dout shows the head entry whenever empty=0; flags are registered from the
// next-state count so no request input reaches full/empty/count combinationally.
module sample_fifo
  import sample_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_W,
  parameter int DEPTH      = FIFO_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      din,
  output logic                       full,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;

  // Accept decisions from current flags, then next pointers, count and flags.
  always_comb begin
    wr_acc      = wr_en & ~full_q;
    rd_acc      = rd_en & ~empty_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q | (wr_en & full_q);
    underflow_d = underflow_q | (rd_en & empty_q);
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  // State register and storage; reset discards entries but leaves mem as-is.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      if (wr_acc) mem[wr_ptr_q] <= din;
    end
  end

  assign dout      = mem[rd_ptr_q];
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule : sample_fifo

// File: tb/tb_sample_fifo.sv
// Directed plus randomized bench for sample_fifo against a queue-based model.
module tb_sample_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] din   = '0;
  logic          full;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic          empty;
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of stored words plus sticky error flags.
  logic [DW-1:0] mq[$];
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  sample_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .din      (din),
    .full     (full),
    .rd_en    (rd_en),
    .dout     (dout),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every observable output with the model.
  task automatic check_all(input string tag);
    chk({tag, ".empty"}, 64'(empty), 64'(mq.size() == 0));
    chk({tag, ".full"}, 64'(full), 64'(mq.size() == DEPTH));
    chk({tag, ".count"}, 64'(count), 64'(mq.size()));
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".unf"}, 64'(underflow), 64'(m_unf));
    if (mq.size() > 0) chk({tag, ".dout"}, 64'(dout), 64'(mq[0]));
  endtask

  // One clock: drive requests, advance the model on the edge, check after it.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic rs, input string tag);
    bit w_ok, r_ok;
    wr_en = w; din = d; rd_en = r; reset = rs;
    @(posedge clock);
    if (rs) begin
      mq.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      w_ok = w && (mq.size() < DEPTH);
      r_ok = r && (mq.size() > 0);
      if (w && !w_ok) m_ovf = 1;
      if (r && mq.size() == 0) m_unf = 1;
      if (r_ok) void'(mq.pop_front());
      if (w_ok) mq.push_back(d);
    end
    #1;
    wr_en = 0; rd_en = 0; reset = 0;
    check_all(tag);
  endtask

  initial begin
    logic [DW-1:0] v;

    // Reset then idle.
    cycle(0, '0, 0, 1, "rst");
    for (int i = 0; i < 5; i++) cycle(0, '0, 0, 0, "idle");
    chk("idle_empty", 64'(empty), 64'd1);

    // FWFT single word.
    cycle(1, 32'h0000_1234, 0, 0, "wr1234");
    chk("fwft_dout", 64'(dout), 64'h1234);
    chk("fwft_count", 64'(count), 64'd1);
    cycle(0, '0, 1, 0, "rd1234");
    chk("after_rd_empty", 64'(empty), 64'd1);

    // Fill, overflow, wrap.
    for (int i = 0; i < 16; i++) cycle(1, DW'(i), 0, 0, "fill");
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count", 64'(count), 64'd16);
    cycle(1, 32'd99, 0, 0, "wr99");
    chk("ovf_set", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("rd_head", 64'(dout), 64'(i));
      cycle(0, '0, 1, 0, "rd4");
    end
    for (int i = 16; i < 20; i++) cycle(1, DW'(i), 0, 0, "wrap_wr");
    for (int i = 4; i < 20; i++) begin
      chk("wrap_order", 64'(dout), 64'(i));
      cycle(0, '0, 1, 0, "wrap_rd");
    end
    chk("wrap_empty", 64'(empty), 64'd1);

    // Empty + both requests.
    cycle(0, '0, 0, 1, "rst2");
    cycle(1, 32'd7, 1, 0, "empty_both");
    chk("eb_unf", 64'(underflow), 64'd1);
    chk("eb_count", 64'(count), 64'd1);
    chk("eb_dout", 64'(dout), 64'd7);

    // Full + both requests.
    for (int i = 0; i < 15; i++) cycle(1, DW'(100 + i), 0, 0, "fill2");
    chk("fill2_full", 64'(full), 64'd1);
    cycle(1, 32'hDEAD, 1, 0, "full_both");
    chk("fb_count", 64'(count), 64'd15);
    chk("fb_ovf", 64'(overflow), 64'd1);
    chk("fb_head", 64'(dout), 64'd100);
    for (int i = 0; i < 15; i++) begin
      chk("fb_drain_no_dead", 64'(dout == 32'hDEAD), 64'd0);
      cycle(0, '0, 1, 0, "fb_drain");
    end

    // Steady streaming with signed samples.
    cycle(0, '0, 0, 1, "rst3");
    cycle(1, DW'(-5), 0, 0, "prime");
    for (int i = 1; i <= 24; i++) begin
      v = DW'(-5 + i - 1);
      chk("stream_dout", 64'(dout), 64'(v));
      cycle(1, DW'(-5 + i), 1, 0, "stream");
      chk("stream_count", 64'(count), 64'd1);
    end
    chk("stream_ovf", 64'(overflow), 64'd0);
    chk("stream_unf", 64'(underflow), 64'd0);
    cycle(0, '0, 1, 0, "stream_drain");

    // Reset mid-operation with count=9 and overflow set.
    for (int i = 0; i < 17; i++) cycle(1, DW'(200 + i), 0, 0, "fill3");
    for (int i = 0; i < 7; i++) cycle(0, '0, 1, 0, "part_rd");
    chk("pre_rst_count", 64'(count), 64'd9);
    chk("pre_rst_ovf", 64'(overflow), 64'd1);
    cycle(1, 32'd55, 1, 1, "mid_rst");
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    cycle(1, 32'd42, 0, 0, "wr42");
    chk("rd42", 64'(dout), 64'd42);
    cycle(0, '0, 1, 0, "rd42_pop");

    // Randomized traffic: write-heavy phase then read-heavy phase.
    for (int i = 0; i < 600; i++) begin
      logic w, r, rs;
      int wp;
      wp = (i < 300) ? 70 : 30;
      w  = ($urandom_range(99) < wp);
      r  = ($urandom_range(99) < (100 - wp));
      rs = ($urandom_range(127) == 0);
      cycle(w, DW'($urandom), r, rs, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sample_fifo
